// File: rtl/relu_seq_ctrl.sv
// Sequenced ReLU over additively shared operands: reconstructs x = g + e, clips
// negatives to zero and streams results through a single output register.
module relu_seq_ctrl #(
    parameter int N  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] cfg_len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  g_input,
    input  logic [N-1:0]  e_input,
    output logic [N-1:0]  o,
    output logic          o_valid,
    input  logic          o_ready,
    output logic          o_last,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] neg_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [1:0]    state;
    logic [CW-1:0] len_q;
    logic [CW-1:0] elem_cnt;
    logic [N-1:0]  x;
    logic          x_neg;
    logic          accept;
    logic          consume;
    logic          elem_last;

    // Carry-out of the share sum is dropped: reconstruction is mod 2^N.
    assign x         = g_input + e_input;
    assign x_neg     = x[N-1];
    assign in_ready  = (state == RUN) && (!o_valid || o_ready);
    assign accept    = in_valid && in_ready;
    assign consume   = o_valid && o_ready;
    assign elem_last = (elem_cnt == len_q - CNT_ONE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // NOTE: every register below uses non-blocking assignment so all state
    // updates see the pre-edge values of their neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            len_q    <= '0;
            elem_cnt <= '0;
            neg_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        neg_cnt <= '0;
                        if (cfg_len != '0) begin
                            len_q    <= cfg_len;
                            elem_cnt <= '0;
                            state    <= RUN;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (elem_last) begin
                            state <= DRAIN;
                        end else begin
                            elem_cnt <= elem_cnt + CNT_ONE;
                        end
                        if (x_neg && neg_cnt != CNT_MAX) begin
                            neg_cnt <= neg_cnt + CNT_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (consume && o_last) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Single output stage: a new element may replace the one being consumed
    // in the same cycle, giving one element per cycle when o_ready stays high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o       <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end else if (accept) begin
            o       <= x_neg ? '0 : x;
            o_valid <= 1'b1;
            o_last  <= elem_last;
        end else if (consume) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_relu_seq_ctrl.sv
// Randomized and directed bench for relu_seq_ctrl against a queue-based
// reference of the job: expected results are derived from the shares alone.
module tb_relu_seq_ctrl;

    localparam int N  = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] cfg_len;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  g_input;
    logic [N-1:0]  e_input;
    logic [N-1:0]  o;
    logic          o_valid;
    logic          o_ready;
    logic          o_last;
    logic          busy;
    logic          done;
    logic [CW-1:0] neg_cnt;

    int vectors    = 0;
    int miscompares = 0;

    int dir_g[$];
    int dir_e[$];

    relu_seq_ctrl #(.N(N), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_len  (cfg_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .g_input  (g_input),
        .e_input  (e_input),
        .o        (o),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_last   (o_last),
        .busy     (busy),
        .done     (done),
        .neg_cnt  (neg_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called just after a falling edge with the block idle. Returns just after
    // a falling edge with the block idle again.
    task automatic run_job(input int len, input bit rnd, input int stall_first);
        int  exp_q[$];
        int  acc = 0;
        int  recv = 0;
        int  negs = 0;
        int  stall = 0;
        int  budget = 0;
        int  x;
        bit  pending = 0;
        bit  exp_rdy;

        start   = 1'b1;
        cfg_len = CW'(len);
        @(negedge clk);
        start = 1'b0;

        if (len == 0) begin
            #1;
            check("empty_busy", busy, 1);
            check("empty_done", done, 1);
            check("empty_ovalid", o_valid, 0);
            check("empty_negcnt", neg_cnt, 0);
            @(negedge clk);
            #1;
            check("empty_busy_after", busy, 0);
            check("empty_done_after", done, 0);
            return;
        end

        while (recv < len && budget < 2000) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!rnd && acc < len) begin
                g_input = N'(dir_g[acc]);
                e_input = N'(dir_e[acc]);
            end else begin
                g_input = N'($urandom);
                e_input = N'($urandom);
            end
            if (pending && recv == 0 && stall < stall_first) begin
                o_ready = 1'b0;
                stall++;
            end else begin
                o_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            start   = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
            cfg_len = CW'($urandom);
            #1;

            exp_rdy = (acc < len) && (!pending || o_ready);
            check("in_ready", in_ready, exp_rdy);
            check("o_valid", o_valid, pending);
            check("busy", busy, 1);
            check("done_early", done, 0);
            check("neg_cnt_run", neg_cnt, negs);
            if (pending) begin
                check("o", o, exp_q[recv]);
                check("o_last", o_last, (recv == len - 1));
            end

            if (pending && o_ready) begin
                recv++;
                pending = 0;
            end
            if (in_valid && exp_rdy) begin
                x = (int'(g_input) + int'(e_input)) % (1 << N);
                exp_q.push_back((x >= (1 << (N - 1))) ? 0 : x);
                if (x >= (1 << (N - 1))) negs++;
                acc++;
                pending = 1;
            end
            budget++;
            @(negedge clk);
        end

        if (budget >= 2000) check("job_timeout", 1, 0);
        start    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("done_pulse", done, 1);
        check("busy_done", busy, 1);
        check("o_valid_done", o_valid, 0);
        @(negedge clk);
        #1;
        check("done_cleared", done, 0);
        check("busy_idle", busy, 0);
        check("neg_cnt_final", neg_cnt, negs);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        cfg_len  = '0;
        in_valid = 1'b0;
        o_ready  = 1'b0;
        g_input  = '0;
        e_input  = '0;
        #2;
        check("rst_o", o, 0);
        check("rst_o_valid", o_valid, 0);
        check("rst_o_last", o_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_neg_cnt", neg_cnt, 0);
        check("rst_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Reference vectors with wrap-around and sign-bit boundary shares.
        dir_g = '{10, 200, 0};
        dir_e = '{20, 100, 127};
        run_job(3, 0, 0);
        dir_g = '{100, 255};
        dir_e = '{28, 1};
        run_job(2, 0, 0);
        dir_g = '{5, 7};
        dir_e = '{6, 8};
        run_job(2, 0, 4);
        run_job(0, 0, 0);

        // Abort a job after one of four elements with the result still pending.
        start   = 1'b1;
        cfg_len = CW'(4);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        g_input  = N'(10);
        e_input  = N'(20);
        o_ready  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("abort_pending", o_valid, 1);
        check("abort_value", o, 30);
        start = 1'b1;
        #1;
        check("start_in_run_ignored", busy, 1);
        start = 1'b0;
        rst   = 1'b0;
        #1;
        check("abort_o", o, 0);
        check("abort_o_valid", o_valid, 0);
        check("abort_o_last", o_last, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_neg_cnt", neg_cnt, 0);
        @(negedge clk);
        #1;
        check("abort_no_done", done, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int j = 0; j < 20; j++) begin
            run_job($urandom_range(1, 12), 1, 0);
        end
        run_job(0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
